data_axi_bridge: RTL and testbench
==================================

DATA_AXI_BRIDGE -- requirements
Module: data_axi_bridge

Interface
REQ-001 SHALL have parameters: AXI_ID, default 4'd1, ARID/AWID driven on every transfer; ADDR_W, default 32, address width.
REQ-002 SHALL have ports (clock and reset first):
clk  in  1  sole clock, rising edge
rst  in  1  asynchronous, active-low reset
mem_en  in  1  data request valid (memrenM|memwenM of mem stage)
mem_wen  in  4  byte write mask; 0 = read
mem_addr  in  32  byte address
mem_wdata  in  32  write data, lane-aligned
longest_stall  in  1  pipeline-wide stall
mem_rdata  out  32  read data, valid in DONE
d_stall  out  1  holds mem stage while access is pending
arid/araddr/arlen/arsize/arvalid  out  4/32/8/3/1  AXI read address
arready  in  1
rid/rdata/rresp/rlast/rvalid  in  4/32/2/1/1  AXI read data
rready  out  1
awid/awaddr/awlen/awsize/awvalid  out  4/32/8/3/1  AXI write address
awready  in  1
wid/wdata/wstrb/wlast/wvalid  out  4/32/4/1/1  AXI write data
wready  in  1
bid/bresp/bvalid  in  4/2/1
bready  out  1

Function
REQ-003 SHALL use FSM states IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE.
REQ-004 IDLE: mem_en=1 with mem_wen==0 -> RD_ADDR; mem_en=1 with mem_wen!=0 -> WR_REQ; else stay.
REQ-005 d_stall SHALL be combinationally 1 when (IDLE and mem_en) or state in {RD_ADDR, RD_DATA, WR_REQ, WR_RESP}; 0 in DONE and in idle IDLE.
REQ-006 Request fields SHALL be latched on leaving IDLE; later changes to mem_* SHALL be ignored until return to IDLE.
REQ-007 RD_ADDR: arvalid=1, araddr=latched addr, arlen=0, arsize=3'd2; on arvalid&arready -> RD_DATA.
REQ-008 RD_DATA: rready=1; on rvalid, latch rdata into mem_rdata -> DONE; rresp is ignored.
REQ-009 WR_REQ: awvalid and wvalid asserted together, awlen=0, wlast=1, wstrb=latched mask; awsize and awaddr[1:0] derived from mask (0001/0010/0100/1000 -> size 0, offset 0..3; 0011/1100 -> size 1, offset 0/2; 1111 -> size 2, offset 0).
REQ-010 AW and W handshakes SHALL be tracked independently; each valid drops after its own handshake; both done -> WR_RESP (per REQ-016).
REQ-011 WR_RESP: bready=1; bvalid -> DONE.
REQ-012 DONE: d_stall=0, mem_rdata held; stay while longest_stall=1; -> IDLE when longest_stall=0, so a request held in mem stage is never reissued.
REQ-013 Simultaneous arvalid/arready and state entry SHALL complete in one cycle (min read: IDLE -> RD_ADDR -> RD_DATA -> DONE = 3 cycles of d_stall).
REQ-014 AXI valids SHALL never drop before their handshake; no other AXI output SHALL change while its valid is high.

Reset
REQ-015 rst low SHALL asynchronously force IDLE, all valids/readies 0, mem_rdata=0, latched fields 0, d_stall=0 (mem_en low), IDs=AXI_ID. Mid-transfer reset abandons the transfer.

Configuration
REQ-016 Macro D_BRIDGE_BRESP_EN: defined -> write path as REQ-011. Undefined -> WR_RESP state absent, bready tied 1, bvalid ignored, WR_REQ goes directly to DONE once both AW and W handshakes are done.

Structure
REQ-017 FSM state enum, AXI size encodings and default ID SHALL live in shared package mips_axi_pkg.
REQ-018 Mask-to-size/offset decode SHALL be sub-module strb2size (combinational); FSM stays in data_axi_bridge.

Verification
REQ-019 Read: mem_en=1, wen=0, addr=0x1FC0_0010, arready=1 immediately, rdata=0xDEAD_BEEF one cycle later -> araddr=0x1FC0_0010, arsize=2, mem_rdata=0xDEAD_BEEF, d_stall high exactly 3 cycles.
REQ-020 Byte store: wen=4'b0100, addr=0x8000_0001, wdata=0x00AB_0000 -> awaddr=0x8000_0002, awsize=0, wstrb=0100, DONE after bvalid.
REQ-021 Skewed write: wready 4 cycles before awready -> wvalid drops after its handshake, awvalid holds, single AW and single W beat observed.
REQ-022 longest_stall=1 for 5 cycles in DONE -> no second arvalid; returns to IDLE on first cycle longest_stall=0.
REQ-023 rst low during RD_DATA -> IDLE, rready=0, d_stall=0 same cycle; with D_BRIDGE_BRESP_EN undefined, write completes with bvalid never asserted.

Source files
------------

// File: rtl/mips_axi_pkg.sv
// Shared definitions for the data-side AXI bridge.
//   bridgeState_t  : bridge FSM state encoding
//   AXI_SIZE_*     : AXI AxSIZE encodings for 1/2/4-byte beats
//   AXI_DEFAULT_ID : default ARID/AWID/WID value
// Optional macro D_BRIDGE_BRESP_EN adds the WR_RESP state (write response wait).
package mips_axi_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RD_ADDR = 3'd1,
      RD_DATA = 3'd2,
      WR_REQ  = 3'd3,
`ifdef D_BRIDGE_BRESP_EN
      WR_RESP = 3'd4,
`endif
      DONE    = 3'd5
   } bridgeState_t;

   localparam logic [2:0] AXI_SIZE_1B = 3'd0;
   localparam logic [2:0] AXI_SIZE_2B = 3'd1;
   localparam logic [2:0] AXI_SIZE_4B = 3'd2;

   localparam logic [3:0] AXI_DEFAULT_ID = 4'd1;

endpackage

// File: rtl/strb2size.sv
// Combinational decode of a byte-write mask into AXI size and low address bits.
//   strb   in  4 : byte lane mask
//   size   out 3 : AXI AxSIZE
//   offset out 2 : address[1:0] of the lowest enabled lane
// Masks other than single bytes, aligned halves or the full word fall back to a
// full-word access.
module strb2size
   import mips_axi_pkg::*;
(
   input  logic [3:0] strb,
   output logic [2:0] size,
   output logic [1:0] offset
);

   always_comb begin
      size   = AXI_SIZE_4B;
      offset = 2'd0;
      case (strb)
         4'b0001: begin size = AXI_SIZE_1B; offset = 2'd0; end
         4'b0010: begin size = AXI_SIZE_1B; offset = 2'd1; end
         4'b0100: begin size = AXI_SIZE_1B; offset = 2'd2; end
         4'b1000: begin size = AXI_SIZE_1B; offset = 2'd3; end
         4'b0011: begin size = AXI_SIZE_2B; offset = 2'd0; end
         4'b1100: begin size = AXI_SIZE_2B; offset = 2'd2; end
         default: begin size = AXI_SIZE_4B; offset = 2'd0; end
      endcase
   end

endmodule

// File: rtl/data_axi_bridge.sv
// Bridges the mem-stage data request of the pipeline onto single-beat AXI
// reads and writes, stalling the mem stage while an access is outstanding.
//   clk, rst (async, active low)
//   mem_en/mem_wen/mem_addr/mem_wdata : request from mem stage (wen==0 -> read)
//   longest_stall                      : pipeline-wide stall, holds DONE
//   mem_rdata, d_stall                 : read result and mem-stage stall
//   ar*/r*/aw*/w*/b*                   : AXI master channels
// Macro D_BRIDGE_BRESP_EN: when defined, writes wait for BVALID in WR_RESP;
// otherwise BREADY is tied high and writes finish once AW and W are accepted.
module data_axi_bridge
   import mips_axi_pkg::*;
#(
   parameter logic [3:0]  AXI_ID = AXI_DEFAULT_ID,
   parameter int unsigned ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              mem_en,
   input  logic [3:0]        mem_wen,
   input  logic [31:0]       mem_addr,
   input  logic [31:0]       mem_wdata,
   input  logic              longest_stall,
   output logic [31:0]       mem_rdata,
   output logic              d_stall,
   output logic [3:0]        arid,
   output logic [ADDR_W-1:0] araddr,
   output logic [7:0]        arlen,
   output logic [2:0]        arsize,
   output logic              arvalid,
   input  logic              arready,
   input  logic [3:0]        rid,
   input  logic [31:0]       rdata,
   input  logic [1:0]        rresp,
   input  logic              rlast,
   input  logic              rvalid,
   output logic              rready,
   output logic [3:0]        awid,
   output logic [ADDR_W-1:0] awaddr,
   output logic [7:0]        awlen,
   output logic [2:0]        awsize,
   output logic              awvalid,
   input  logic              awready,
   output logic [3:0]        wid,
   output logic [31:0]       wdata,
   output logic [3:0]        wstrb,
   output logic              wlast,
   output logic              wvalid,
   input  logic              wready,
   input  logic [3:0]        bid,
   input  logic [1:0]        bresp,
   input  logic              bvalid,
   output logic              bready
);

   bridgeState_t stateQ, stateD;

   logic [ADDR_W-1:0] addrQ;
   logic [3:0]        wenQ;
   logic [31:0]       wdataQ;
   logic [31:0]       rdataQ;
   logic              awDoneQ, wDoneQ;
   logic              awDoneNow, wDoneNow;
   logic [1:0]        wrOffset;

   // Response IDs, last flags and status are not used by this single-beat master.
`ifdef D_BRIDGE_BRESP_EN
   logic unusedAxi;
   assign unusedAxi = ^{rid, rresp, rlast, bid, bresp};
`else
   logic unusedAxi;
   assign unusedAxi = ^{rid, rresp, rlast, bid, bresp, bvalid};
   assign bready    = 1'b1;
`endif

   strb2size u_strb2size (
      .strb   (wenQ),
      .size   (awsize),
      .offset (wrOffset)
   );

   // A channel counts as done once its handshake happened this cycle or earlier.
   assign awDoneNow = awDoneQ | (awvalid & awready);
   assign wDoneNow  = wDoneQ  | (wvalid  & wready);

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stateQ <= IDLE;
      end else begin
         stateQ <= stateD;
      end
   end

   // Next-state logic
   always_comb begin
      stateD = stateQ;
      case (stateQ)
         IDLE:    if (mem_en) stateD = (mem_wen == 4'd0) ? RD_ADDR : WR_REQ;
         RD_ADDR: if (arready) stateD = RD_DATA;
         RD_DATA: if (rvalid) stateD = DONE;
`ifdef D_BRIDGE_BRESP_EN
         WR_REQ:  if (awDoneNow && wDoneNow) stateD = WR_RESP;
         WR_RESP: if (bvalid) stateD = DONE;
`else
         WR_REQ:  if (awDoneNow && wDoneNow) stateD = DONE;
`endif
         DONE:    if (!longest_stall) stateD = IDLE;
         default: stateD = IDLE;
      endcase
   end

   // Outputs
   always_comb begin
      arvalid = 1'b0;
      rready  = 1'b0;
      awvalid = 1'b0;
      wvalid  = 1'b0;
      d_stall = 1'b0;
`ifdef D_BRIDGE_BRESP_EN
      bready  = 1'b0;
`endif
      case (stateQ)
         IDLE:    d_stall = mem_en;
         RD_ADDR: begin arvalid = 1'b1; d_stall = 1'b1; end
         RD_DATA: begin rready  = 1'b1; d_stall = 1'b1; end
         WR_REQ: begin
            awvalid = ~awDoneQ;
            wvalid  = ~wDoneQ;
            d_stall = 1'b1;
         end
`ifdef D_BRIDGE_BRESP_EN
         WR_RESP: begin bready = 1'b1; d_stall = 1'b1; end
`endif
         default: d_stall = 1'b0;
      endcase
   end

   // Request capture, read data and per-channel write progress
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         addrQ   <= '0;
         wenQ    <= 4'd0;
         wdataQ  <= 32'd0;
         rdataQ  <= 32'd0;
         awDoneQ <= 1'b0;
         wDoneQ  <= 1'b0;
      end else begin
         // Fields are frozen for the whole access; mem_* may change meanwhile.
         if (stateQ == IDLE && mem_en) begin
            addrQ  <= mem_addr[ADDR_W-1:0];
            wenQ   <= mem_wen;
            wdataQ <= mem_wdata;
         end
         if (stateQ == RD_DATA && rvalid) begin
            rdataQ <= rdata;
         end
         if (stateQ == WR_REQ && stateD == WR_REQ) begin
            awDoneQ <= awDoneNow;
            wDoneQ  <= wDoneNow;
         end else begin
            awDoneQ <= 1'b0;
            wDoneQ  <= 1'b0;
         end
      end
   end

   assign arid      = AXI_ID;
   assign araddr    = addrQ;
   assign arlen     = 8'd0;
   assign arsize    = AXI_SIZE_4B;
   assign awid      = AXI_ID;
   assign awaddr    = {addrQ[ADDR_W-1:2], wrOffset};
   assign awlen     = 8'd0;
   assign wid       = AXI_ID;
   assign wdata     = wdataQ;
   assign wstrb     = wenQ;
   assign wlast     = 1'b1;
   assign mem_rdata = rdataQ;

endmodule

// File: tb/tb_data_axi_bridge.sv
// Scoreboard bench for data_axi_bridge: a driver issues mem-stage requests and
// pushes expected AXI beats/completions; a latency-programmable AXI slave model
// answers; a negedge monitor pops and compares.
module tb_data_axi_bridge;

   localparam logic [3:0] ID = 4'd1;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_en, longest_stall;
   logic [3:0]  mem_wen;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic        d_stall;
   logic [3:0]  arid, rid, awid, wid, bid;
   logic [31:0] araddr, awaddr, rdata, wdata;
   logic [7:0]  arlen, awlen;
   logic [2:0]  arsize, awsize;
   logic        arvalid, arready, rlast, rvalid, rready;
   logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
   logic [1:0]  rresp, bresp;
   logic [3:0]  wstrb;

   data_axi_bridge #(.AXI_ID(ID), .ADDR_W(32)) dut (
      .clk(clk), .rst(rst), .mem_en(mem_en), .mem_wen(mem_wen), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .longest_stall(longest_stall), .mem_rdata(mem_rdata),
      .d_stall(d_stall), .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
      .arvalid(arvalid), .arready(arready), .rid(rid), .rdata(rdata), .rresp(rresp),
      .rlast(rlast), .rvalid(rvalid), .rready(rready), .awid(awid), .awaddr(awaddr),
      .awlen(awlen), .awsize(awsize), .awvalid(awvalid), .awready(awready), .wid(wid),
      .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
      .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
   );

   always #5 clk = ~clk;

   typedef struct {logic [31:0] addr; logic [2:0] size;} addrExp_t;
   typedef struct {logic [31:0] data; logic [3:0] strb;} wExp_t;
   typedef struct {bit isRead; int stall;} compExp_t;

   addrExp_t    arQ[$], awQ[$];
   wExp_t       wQ[$];
   compExp_t    compQ[$];
   logic [31:0] rdQ[$];

   int checks = 0, failures = 0;
   int arLat = 0, rLat = 0, awLat = 0, wLat = 0, bLat = 0;
   bit noB = 0, useFixed = 0;
   logic [31:0] fixedRdata = 32'd0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
      end
   endtask

   task automatic chkBit(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%b required=%b", name, act, exp);
      end
   endtask

   task automatic finishRun;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   endtask

   // Reference: lowest enabled lane gives the offset, lane count gives the size.
   function automatic void maskDecode(input logic [3:0] m, output logic [2:0] size,
                                      output logic [1:0] off);
      int n = 0;
      int low = -1;
      for (int i = 0; i < 4; i++) begin
         if (m[i]) begin
            n++;
            if (low < 0) low = i;
         end
      end
      off  = 2'(low);
      size = (n == 4) ? 3'd2 : (n == 2) ? 3'd1 : 3'd0;
   endfunction

   // ---------------- AXI slave model ----------------
   bit sArHs, sRHs, sAwHs, sWHs, sBHs;
   bit rPend, awSeen, wSeen, bPend;
   int arCnt, rCnt, awCnt, wCnt, bCnt;

   initial begin
      arready = 0; rvalid = 0; rdata = 0; rresp = 0; rlast = 1; rid = ID;
      awready = 0; wready = 0; bvalid = 0; bresp = 0; bid = ID;
      rPend = 0; awSeen = 0; wSeen = 0; bPend = 0;
      arCnt = 0; rCnt = 0; awCnt = 0; wCnt = 0; bCnt = 0;
      forever begin
         @(negedge clk);
         sArHs = arvalid & arready;
         sRHs  = rvalid & rready;
         sAwHs = awvalid & awready;
         sWHs  = wvalid & wready;
         sBHs  = bvalid & bready;
         @(posedge clk);
         #1;
         if (!rst) begin
            arready = 0; rvalid = 0; awready = 0; wready = 0; bvalid = 0;
            rPend = 0; awSeen = 0; wSeen = 0; bPend = 0;
            arCnt = 0; rCnt = 0; awCnt = 0; wCnt = 0; bCnt = 0;
         end else begin
            if (sArHs) begin
               arready = 0; arCnt = 0; rPend = 1; rCnt = 0;
            end else if (arvalid && !arready) begin
               if (arCnt >= arLat) arready = 1; else arCnt++;
            end
            if (sRHs) rvalid = 0;
            if (rPend && !rvalid) begin
               if (rCnt >= rLat) begin
                  rvalid = 1;
                  rdata  = useFixed ? fixedRdata : $urandom;
                  rresp  = 2'($urandom);
                  rdQ.push_back(rdata);
                  rPend  = 0;
               end else rCnt++;
            end
            if (sAwHs) begin
               awready = 0; awCnt = 0; awSeen = 1;
            end else if (awvalid && !awready) begin
               if (awCnt >= awLat) awready = 1; else awCnt++;
            end
            if (sWHs) begin
               wready = 0; wCnt = 0; wSeen = 1;
            end else if (wvalid && !wready) begin
               if (wCnt >= wLat) wready = 1; else wCnt++;
            end
            if (awSeen && wSeen) begin
               awSeen = 0; wSeen = 0; bPend = 1; bCnt = 0;
            end
            if (sBHs) bvalid = 0;
            if (bPend && !bvalid && !noB) begin
               if (bCnt >= bLat) begin
                  bvalid = 1; bresp = 2'($urandom); bPend = 0;
               end else bCnt++;
            end
         end
      end
   end

   // ---------------- Monitor / scoreboard ----------------
   bit          pArv, pArr, pAwv, pAwr, pWv, pWr, prevStall;
   logic [31:0] pAraddr, pAwaddr, pWdata, lastRd;
   logic [2:0]  pAwsize;
   logic [3:0]  pWstrb;
   int          stallRun;
   addrExp_t    mA;
   wExp_t       mW;
   compExp_t    mC;
   logic [31:0] mR;

   initial begin
      lastRd = 0; stallRun = 0; prevStall = 0;
   end

   always @(negedge clk) begin
      if (!rst) begin
         pArv = 0; pArr = 0; pAwv = 0; pAwr = 0; pWv = 0; pWr = 0;
         prevStall = 0; stallRun = 0; lastRd = 0;
      end else begin
         if (pArv && !pArr) begin
            chkBit("ar_valid_hold", arvalid, 1'b1);
            chk("ar_addr_stable", araddr, pAraddr);
         end
         if (pAwv && !pAwr) begin
            chkBit("aw_valid_hold", awvalid, 1'b1);
            chk("aw_addr_stable", awaddr, pAwaddr);
            chk("aw_size_stable", 32'(awsize), 32'(pAwsize));
         end
         if (pWv && !pWr) begin
            chkBit("w_valid_hold", wvalid, 1'b1);
            chk("w_data_stable", wdata, pWdata);
            chk("w_strb_stable", 32'(wstrb), 32'(pWstrb));
         end
         if (arvalid && arready) begin
            if (arQ.size() == 0) chkBit("ar_extra_beat", 1'b1, 1'b0);
            else begin
               mA = arQ.pop_front();
               chk("araddr", araddr, mA.addr);
               chk("arsize", 32'(arsize), 32'(mA.size));
               chk("arlen", 32'(arlen), 32'd0);
               chk("arid", 32'(arid), 32'(ID));
            end
         end
         if (awvalid && awready) begin
            if (awQ.size() == 0) chkBit("aw_extra_beat", 1'b1, 1'b0);
            else begin
               mA = awQ.pop_front();
               chk("awaddr", awaddr, mA.addr);
               chk("awsize", 32'(awsize), 32'(mA.size));
               chk("awlen", 32'(awlen), 32'd0);
               chk("awid", 32'(awid), 32'(ID));
            end
         end
         if (wvalid && wready) begin
            if (wQ.size() == 0) chkBit("w_extra_beat", 1'b1, 1'b0);
            else begin
               mW = wQ.pop_front();
               chk("wdata", wdata, mW.data);
               chk("wstrb", 32'(wstrb), 32'(mW.strb));
               chkBit("wlast", wlast, 1'b1);
               chk("wid", 32'(wid), 32'(ID));
            end
         end
         if (d_stall) stallRun++;
         else if (prevStall) begin
            if (compQ.size() == 0) chkBit("completion_extra", 1'b1, 1'b0);
            else begin
               mC = compQ.pop_front();
               chk("stall_cycles", stallRun, mC.stall);
               if (mC.isRead) begin
                  if (rdQ.size() == 0) chkBit("rdata_missing", 1'b1, 1'b0);
                  else begin
                     mR = rdQ.pop_front();
                     chk("mem_rdata", mem_rdata, mR);
                     lastRd = mR;
                  end
               end else begin
                  chk("mem_rdata_held", mem_rdata, lastRd);
               end
            end
            stallRun = 0;
         end
         prevStall = d_stall;
         pArv = arvalid; pArr = arready; pAraddr = araddr;
         pAwv = awvalid; pAwr = awready; pAwaddr = awaddr; pAwsize = awsize;
         pWv = wvalid; pWr = wready; pWdata = wdata; pWstrb = wstrb;
      end
   end

   // ---------------- Driver ----------------
   task automatic doReq(input bit isRead, input logic [31:0] addr, input logic [3:0] wen,
                        input logic [31:0] data, input int hold, input bit noGap);
      addrExp_t a;
      wExp_t    w;
      compExp_t c;
      logic [2:0] sz;
      logic [1:0] off;
      int n;
      if (!noGap) begin
         @(posedge clk);
         #1;
      end
      mem_en        = 1;
      mem_wen       = isRead ? 4'd0 : wen;
      mem_addr      = addr;
      mem_wdata     = data;
      longest_stall = (hold > 0);
      c.isRead = isRead;
      if (isRead) begin
         a.addr = addr; a.size = 3'd2;
         arQ.push_back(a);
         c.stall = 3 + arLat + rLat;
      end else begin
         maskDecode(wen, sz, off);
         a.addr = {addr[31:2], off}; a.size = sz;
         awQ.push_back(a);
         w.data = data; w.strb = wen;
         wQ.push_back(w);
         c.stall = 2 + ((awLat > wLat) ? awLat : wLat);
`ifdef D_BRIDGE_BRESP_EN
         c.stall = c.stall + bLat + 1;
`endif
      end
      compQ.push_back(c);
      @(negedge clk);
      chkBit("stall_first", d_stall, 1'b1);
      n = 0;
      while (d_stall) begin
         // Scramble the request while it is held; the bridge must ignore it.
         @(posedge clk);
         #1;
         mem_addr  = $urandom;
         mem_wdata = $urandom;
         mem_wen   = 4'($urandom);
         @(negedge clk);
         n++;
         if (n > 100) begin
            chkBit("done_timeout", 1'b0, 1'b1);
            finishRun();
         end
      end
      if (hold > 0) begin
         for (int i = 1; i < hold; i++) begin
            @(negedge clk);
            chkBit("done_hold", d_stall, 1'b0);
         end
         @(posedge clk);
         #1;
         longest_stall = 0;
         @(negedge clk);
         chkBit("done_release", d_stall, 1'b0);
      end
      @(posedge clk);
      #1;
      mem_en = 0;
   endtask

   logic [3:0] masks [7];
   bit         isRd;
   int         hold;

   initial begin
      #1_000_000;
      chkBit("global_timeout", 1'b0, 1'b1);
      finishRun();
   end

   initial begin
      masks = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};
      rst = 0; mem_en = 0; mem_wen = 0; mem_addr = 0; mem_wdata = 0; longest_stall = 0;
      repeat (3) @(negedge clk);
      chkBit("rst_d_stall", d_stall, 1'b0);
      chkBit("rst_arvalid", arvalid, 1'b0);
      chkBit("rst_rready", rready, 1'b0);
      chkBit("rst_awvalid", awvalid, 1'b0);
      chkBit("rst_wvalid", wvalid, 1'b0);
      chk("rst_mem_rdata", mem_rdata, 32'd0);
      chk("rst_araddr", araddr, 32'd0);
      chk("rst_wstrb", 32'(wstrb), 32'd0);
      chk("rst_arid", 32'(arid), 32'(ID));
      chk("rst_awid", 32'(awid), 32'(ID));
      chk("rst_wid", 32'(wid), 32'(ID));
`ifdef D_BRIDGE_BRESP_EN
      chkBit("rst_bready", bready, 1'b0);
`else
      chkBit("rst_bready", bready, 1'b1);
`endif
      @(posedge clk);
      #1;
      rst = 1;

      // Minimum-latency read
      useFixed = 1; fixedRdata = 32'hDEAD_BEEF;
      doReq(1, 32'h1FC0_0010, 4'd0, 32'd0, 0, 0);
      useFixed = 0;

      // Byte store
      bLat = 1;
      doReq(0, 32'h8000_0001, 4'b0100, 32'h00AB_0000, 0, 0);

      // Skewed write: W accepted four cycles before AW
      awLat = 4; wLat = 0; bLat = 0;
      doReq(0, 32'h0000_1230, 4'b1111, 32'h1234_5678, 0, 0);

      // DONE held by longest_stall, then next request on the first free cycle
      awLat = 0;
      doReq(1, 32'h0000_0040, 4'd0, 32'd0, 5, 0);
      doReq(1, 32'h0000_0044, 4'd0, 32'd0, 0, 1);

      // Reset in the middle of a read data wait
      arLat = 0; rLat = 20;
      @(posedge clk);
      #1;
      mem_en = 1; mem_wen = 0; mem_addr = 32'h0000_0100;
      begin
         addrExp_t a;
         a.addr = 32'h0000_0100; a.size = 3'd2;
         arQ.push_back(a);
      end
      for (int i = 0; i < 30 && !rready; i++) @(negedge clk);
      chkBit("rd_data_reached", rready, 1'b1);
      @(posedge clk);
      #3;
      rst = 0; mem_en = 0;
      #1;
      chkBit("midrst_rready", rready, 1'b0);
      chkBit("midrst_d_stall", d_stall, 1'b0);
      chkBit("midrst_arvalid", arvalid, 1'b0);
      chk("midrst_mem_rdata", mem_rdata, 32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1;
      rLat = 0;

`ifndef D_BRIDGE_BRESP_EN
      // Write completes without any write response
      noB = 1; awLat = 1; wLat = 1;
      doReq(0, 32'h0000_2002, 4'b1100, 32'hCAFE_0000, 0, 0);
      noB = 0;
`endif

      for (int t = 0; t < 60; t++) begin
         arLat = $urandom_range(0, 3); rLat = $urandom_range(0, 3);
         awLat = $urandom_range(0, 3); wLat = $urandom_range(0, 3);
         bLat  = $urandom_range(0, 2);
         isRd  = 1'($urandom_range(0, 1));
         hold  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
         doReq(isRd, $urandom, masks[$urandom_range(0, 6)], $urandom, hold,
               1'($urandom_range(0, 1)));
      end

      repeat (5) @(negedge clk);
      chk("queues_drained", 32'(arQ.size() + awQ.size() + wQ.size() + compQ.size() + rdQ.size()),
          32'd0);
      finishRun();
   end

endmodule
